loop_filter: RTL and testbench

//  Digital 2nd-order (proportional + integral) loop filter of the RX CDR.
//  - Input: signed phase-error sample from the phase detector / voter.
//  - Output: 9-bit phase code driving the phase interpolator / rotator.
//  - Integral path tracks frequency offset; proportional path tracks phase.
//  - Gain pair is selected at run time by gainsel.

---
 rtl/cdr_pkg.sv | 14 +
 rtl/sat_add.sv | 22 ++
 rtl/loop_filter.sv | 61 ++++++
 tb/tb_loop_filter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cdr_pkg.sv
// Shared constants and types for the RX CDR digital loop filter.
// Gain shift tables are indexed directly by the 2-bit gain select.
package cdr_pkg;
  localparam int IN_W   = 6;
  localparam int OUT_W  = 9;
  localparam int FRAC_W = 8;
  localparam int FREQ_W = 12;

  typedef logic [1:0] gain_sel_t;

  // Shift amounts in fractional LSBs; entry index = gainsel
  localparam logic [3:0] KP_SH [4] = '{4'd8, 4'd7, 4'd6, 4'd5};
  localparam logic [3:0] KI_SH [4] = '{4'd2, 4'd1, 4'd0, 4'd0};
endpackage

// File: rtl/sat_add.sv
// Signed saturating adder: result clamps to the representable W-bit range.
module sat_add #(
  parameter int W = 12
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum
);
  localparam logic signed [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  logic signed [W:0] full;

  always_comb begin
    full = {a[W-1], a} + {b[W-1], b};
    sum  = full[W-1:0];
    // Overflow shows up as disagreement between the two top bits
    if (full[W] != full[W-1]) begin
      sum = full[W] ? MIN_VAL : MAX_VAL;
    end
  end
endmodule

// File: rtl/loop_filter.sv
// Second-order (P + I) loop filter of the RX CDR: phase error in, rotator code out.
// Frequency register saturates; phase accumulator wraps since the rotator is circular.
module loop_filter
  import cdr_pkg::*;
#(
  parameter int IN_W   = cdr_pkg::IN_W,
  parameter int OUT_W  = cdr_pkg::OUT_W,
  parameter int FRAC_W = cdr_pkg::FRAC_W,
  parameter int FREQ_W = cdr_pkg::FREQ_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  input_signal,
  input  logic [1:0]       gainsel,
  output logic [OUT_W-1:0] output_signal
);
  localparam int PH_W  = OUT_W + FRAC_W;
  localparam int SUM_W = PH_W + 2;

  logic signed [FREQ_W-1:0] freq_q;
  logic        [PH_W-1:0]   phase_q;

  gain_sel_t                gsel;
  logic signed [FREQ_W-1:0] e_freq;
  logic signed [FREQ_W-1:0] ki_term;
  logic signed [FREQ_W-1:0] freq_n;
  logic signed [SUM_W-1:0]  e_ext;
  logic signed [SUM_W-1:0]  kp_term;
  logic signed [SUM_W-1:0]  freq_ext;
  logic signed [SUM_W-1:0]  phase_sum;
  logic [SUM_W-PH_W-1:0]    phase_sum_unused;

  assign gsel     = gainsel;
  assign e_freq   = {{(FREQ_W-IN_W){input_signal[IN_W-1]}}, input_signal};
  assign ki_term  = e_freq <<< KI_SH[gsel];
  assign e_ext    = {{(SUM_W-IN_W){input_signal[IN_W-1]}}, input_signal};
  assign kp_term  = e_ext <<< KP_SH[gsel];

  sat_add #(.W(FREQ_W)) u_freq_add (
    .a   (freq_q),
    .b   (ki_term),
    .sum (freq_n)
  );

  // Phase integrates the already-updated frequency, so a step in e moves both paths at once
  assign freq_ext         = {{(SUM_W-FREQ_W){freq_n[FREQ_W-1]}}, freq_n};
  assign phase_sum        = $signed({2'b00, phase_q}) + kp_term + freq_ext;
  assign phase_sum_unused = phase_sum[SUM_W-1:PH_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      freq_q  <= '0;
      phase_q <= '0;
    end else begin
      freq_q  <= freq_n;
      phase_q <= phase_sum[PH_W-1:0];
    end
  end

  assign output_signal = phase_q[PH_W-1:FRAC_W];
endmodule

// File: tb/tb_loop_filter.sv
// Directed bench for loop_filter: hand-computed checkpoints plus a small integer
// reference model for the longer saturation and wrap sequences.
module tb_loop_filter;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] input_signal;
  logic [1:0] gainsel;
  logic [8:0] output_signal;

  int vectors = 0;
  int errors  = 0;
  int m_freq  = 0;
  int m_phase = 0;

  loop_filter dut (
    .clk           (clk),
    .reset         (reset),
    .input_signal  (input_signal),
    .gainsel       (gainsel),
    .output_signal (output_signal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int kp_of(input logic [1:0] gs);
    case (gs)
      2'd0: return 256;
      2'd1: return 128;
      2'd2: return 64;
      default: return 32;
    endcase
  endfunction

  function automatic int ki_of(input logic [1:0] gs);
    case (gs)
      2'd0: return 4;
      2'd1: return 2;
      default: return 1;
    endcase
  endfunction

  // Apply one edge of stimulus, advance the reference model, sample #1 after the edge
  task automatic step(input int e, input logic [1:0] gs, input logic rst);
    logic [31:0] ev;
    ev = e;
    input_signal = ev[5:0];
    gainsel      = gs;
    reset        = rst;
    @(posedge clk);
    #1;
    if (rst) begin
      m_freq  = 0;
      m_phase = 0;
    end else begin
      m_freq = m_freq + e * ki_of(gs);
      if (m_freq > 2047)  m_freq = 2047;
      if (m_freq < -2048) m_freq = -2048;
      m_phase = m_phase + e * kp_of(gs) + m_freq;
      m_phase = ((m_phase % 131072) + 131072) % 131072;
    end
  endtask

  task automatic step_chk(input string tag, input int e, input logic [1:0] gs);
    step(e, gs, 1'b0);
    check({tag, "_out"}, 32'(output_signal), m_phase / 256);
    check({tag, "_freq"}, 32'($signed(dut.freq_q)), m_freq);
  endtask

  initial begin : stim
    int exp_out [4];
    int exp_ph  [4];
    int prev_out;
    bit saw_wrap;
    exp_out = '{0, 1, 1, 2};
    exp_ph  = '{130, 262, 396, 532};

    input_signal = '0;
    gainsel      = 2'd0;
    reset        = 1'b1;

    // 1: reset dominates a nonzero error
    for (int i = 0; i < 3; i++) begin
      step(5, 2'd0, 1'b1);
      check("rst_out", 32'(output_signal), 0);
      check("rst_freq", 32'($signed(dut.freq_q)), 0);
    end

    // 2: gainsel=01, e=+1 -> PHASE = 128n + n(n+1)
    for (int n = 0; n < 4; n++) begin
      step(1, 2'd1, 1'b0);
      check("ramp_out", 32'(output_signal), exp_out[n]);
      check("ramp_phase", 32'(dut.phase_q), exp_ph[n]);
      check("ramp_freq", 32'($signed(dut.freq_q)), 2 * (n + 1));
    end

    // 3: continue to 50 edges of +1, then reverse and watch the code wrap under 0
    for (int n = 4; n < 50; n++) step(1, 2'd1, 1'b0);
    check("rev_pre_phase", 32'(dut.phase_q), 8950);
    step(-1, 2'd1, 1'b0);
    check("rev_first_freq", 32'($signed(dut.freq_q)), 98);
    saw_wrap = 1'b0;
    prev_out = int'(output_signal);
    for (int n = 0; n < 120; n++) begin
      step_chk("rev", -1, 2'd1);
      if (prev_out < 16 && int'(output_signal) > 495) saw_wrap = 1'b1;
      prev_out = int'(output_signal);
    end
    check("rev_wrap_seen", 32'(saw_wrap), 1);

    // 4: gainsel=00, e=+31 -> +124/edge then pinned at +2047
    step(0, 2'd0, 1'b1);
    step_chk("psat", 31, 2'd0);
    check("psat_first", 32'($signed(dut.freq_q)), 124);
    for (int n = 1; n < 25; n++) step_chk("psat", 31, 2'd0);
    check("psat_rail", 32'($signed(dut.freq_q)), 2047);
    step_chk("psat_leave", -1, 2'd0);
    check("psat_leave_freq", 32'($signed(dut.freq_q)), 2043);

    // 5: gainsel=10, e=-32 -> first edge PHASE = 2^17 - 2048 - 32, code 503
    step(0, 2'd2, 1'b1);
    step(-32, 2'd2, 1'b0);
    check("nsat_phase", 32'(dut.phase_q), 128992);
    check("nsat_out", 32'(output_signal), 503);
    for (int n = 1; n < 70; n++) step_chk("nsat", -32, 2'd2);
    check("nsat_rail", 32'($signed(dut.freq_q)), -2048);
    step(1, 2'd2, 1'b0);
    check("nsat_leave", 32'($signed(dut.freq_q)), -2047);

    // 6: gain switch mid-run, frequency hold with e=0, then mid-run reset
    step(0, 2'd1, 1'b1);
    step(1, 2'd1, 1'b0);
    step(1, 2'd1, 1'b0);
    check("gsw_pre_phase", 32'(dut.phase_q), 262);
    step(1, 2'd3, 1'b0);
    check("gsw_freq", 32'($signed(dut.freq_q)), 5);
    check("gsw_phase", 32'(dut.phase_q), 299);
    check("gsw_out", 32'(output_signal), 1);
    step(0, 2'd3, 1'b0);
    check("hold_freq", 32'($signed(dut.freq_q)), 5);
    check("hold_phase", 32'(dut.phase_q), 304);
    step(7, 2'd3, 1'b1);
    check("midrst_out", 32'(output_signal), 0);
    check("midrst_phase", 32'(dut.phase_q), 0);
    check("midrst_freq", 32'($signed(dut.freq_q)), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
